// File: rtl/ivector_say_arbiter.sv
// Two-requester arbiter in front of a shared IVector say/heard port; a tag FIFO
// routes each heard indication back to the requester that issued the call.
// Optional issue counters are enabled by defining IVECTOR_SAY_ARBITER_STATS_EN.
module ivector_say_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           nRST,

  input  logic                           req0__ENA,
  input  logic [191:0]                   req0_meth,
  input  logic [191:0]                   req0_v,
  output logic                           req0__RDY,

  input  logic                           req1__ENA,
  input  logic [191:0]                   req1_meth,
  input  logic [191:0]                   req1_v,
  output logic                           req1__RDY,

  output logic                           say__ENA,
  output logic [191:0]                   say_meth,
  output logic [191:0]                   say_v,
  input  logic                           say__RDY,

  input  logic                           heard__ENA,
  input  logic [191:0]                   heard_meth,
  input  logic [191:0]                   heard_v,
  output logic                           heard__RDY,

  output logic                           resp0__ENA,
  output logic [191:0]                   resp0_meth,
  output logic [191:0]                   resp0_v,
  input  logic                           resp0__RDY,

  output logic                           resp1__ENA,
  output logic [191:0]                   resp1_meth,
  output logic [191:0]                   resp1_v,
  input  logic                           resp1__RDY,

  output logic [$clog2(TAG_DEPTH):0]     outstanding
`ifdef IVECTOR_SAY_ARBITER_STATS_EN
  ,
  output logic [15:0]                    issued0,
  output logic [15:0]                    issued1
`endif
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic                 prio_q, prio_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;

  logic any_req;
  logic winner;
  logic tag_full;
  logic tag_empty;
  logic grant_ok;
  logic fire0;
  logic fire1;
  logic head_tag;
  logic heard_fire;

  // Grant selection and the say-side handshake.
  always_comb begin
    any_req   = req0__ENA | req1__ENA;
    winner    = (req0__ENA & req1__ENA) ? prio_q : req1__ENA;
    tag_full  = (count_q == CW'(TAG_DEPTH));
    tag_empty = (count_q == '0);
    // Reset gating keeps every handshake quiet while nRST is low.
    grant_ok  = nRST & say__RDY & ~tag_full & any_req;
    req0__RDY = grant_ok & ~winner;
    req1__RDY = grant_ok & winner;
    fire0     = req0__ENA & req0__RDY;
    fire1     = req1__ENA & req1__RDY;
    say__ENA  = fire0 | fire1;
    say_meth  = winner ? req1_meth : req0_meth;
    say_v     = winner ? req1_v    : req0_v;
  end

  // Heard routing: the FIFO head names the requester owed this indication.
  always_comb begin
    head_tag   = tag_q[rd_ptr_q];
    heard__RDY = nRST & ~tag_empty & (head_tag ? resp1__RDY : resp0__RDY);
    heard_fire = heard__ENA & heard__RDY;
    resp0__ENA = heard_fire & ~head_tag;
    resp1__ENA = heard_fire & head_tag;
    resp0_meth = heard_meth;
    resp0_v    = heard_v;
    resp1_meth = heard_meth;
    resp1_v    = heard_v;
  end

  always_comb begin
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    count_d  = count_q;
    if (say__ENA) begin
      tag_d[wr_ptr_q] = winner;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      prio_d          = ~winner;
    end
    if (heard_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({say__ENA, heard_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
    end
  end

  assign outstanding = count_q;

`ifdef IVECTOR_SAY_ARBITER_STATS_EN
  logic [15:0] issued0_q, issued0_d;
  logic [15:0] issued1_q, issued1_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    issued0_d = fire0 ? issued0_q + 16'd1 : issued0_q;
    issued1_d = fire1 ? issued1_q + 16'd1 : issued1_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      issued0_q <= '0;
      issued1_q <= '0;
    end else begin
      issued0_q <= issued0_d;
      issued1_q <= issued1_d;
    end
  end

  assign issued0 = issued0_q;
  assign issued1 = issued1_q;
`endif

endmodule

// File: tb/tb_ivector_say_arbiter.sv
// Scoreboard bench for ivector_say_arbiter: a queue-based reference model predicts
// grants and indication routing; a negedge monitor compares what the DUT presents.
module tb_ivector_say_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic nRST;
  logic req0__ENA, req1__ENA, req0__RDY, req1__RDY;
  logic [191:0] req0_meth, req0_v, req1_meth, req1_v;
  logic say__ENA, say__RDY;
  logic [191:0] say_meth, say_v;
  logic heard__ENA, heard__RDY;
  logic [191:0] heard_meth, heard_v;
  logic resp0__ENA, resp0__RDY, resp1__ENA, resp1__RDY;
  logic [191:0] resp0_meth, resp0_v, resp1_meth, resp1_v;
  logic [CW-1:0] outstanding;
`ifdef IVECTOR_SAY_ARBITER_STATS_EN
  logic [15:0] issued0, issued1;
`endif

  ivector_say_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0__ENA(req0__ENA), .req0_meth(req0_meth), .req0_v(req0_v), .req0__RDY(req0__RDY),
    .req1__ENA(req1__ENA), .req1_meth(req1_meth), .req1_v(req1_v), .req1__RDY(req1__RDY),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .resp0__ENA(resp0__ENA), .resp0_meth(resp0_meth), .resp0_v(resp0_v), .resp0__RDY(resp0__RDY),
    .resp1__ENA(resp1__ENA), .resp1_meth(resp1_meth), .resp1_v(resp1_v), .resp1__RDY(resp1__RDY),
    .outstanding(outstanding)
`ifdef IVECTOR_SAY_ARBITER_STATS_EN
    , .issued0(issued0), .issued1(issued1)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         who;
    logic [191:0] meth;
    logic [191:0] v;
  } txn_t;

  txn_t say_q[$];
  txn_t resp_q[$];

  // Reference model: ordered list of requesters owed an indication, plus round-robin pointer.
  int tagq[$];
  bit prio_m = 1'b0;
  int iss0 = 0, iss1 = 0;

  bit exp_say = 0, exp_rdy0 = 0, exp_rdy1 = 0, exp_hrdy = 0, exp_resp0 = 0, exp_resp1 = 0;
  int exp_out = 0, exp_iss0 = 0, exp_iss1 = 0;
  bit started = 0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] rnd192();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock of stimulus; predicts the cycle, then commits the model after the edge.
  task automatic cyc(input bit rn, input bit r0, input bit r1, input bit srdy,
                     input bit hena, input bit p0, input bit p1, input logic [191:0] hpay);
    bit   win, sfire, hfire;
    int   head;
    txn_t t;
    nRST       = rn;
    req0__ENA  = r0;
    req1__ENA  = r1;
    req0_meth  = rnd192();
    req0_v     = rnd192();
    req1_meth  = rnd192();
    req1_v     = rnd192();
    say__RDY   = srdy;
    heard__ENA = hena;
    heard_meth = hpay;
    heard_v    = ~hpay;
    resp0__RDY = p0;
    resp1__RDY = p1;

    win   = (r0 && r1) ? prio_m : r1;
    sfire = rn && srdy && (r0 || r1) && (tagq.size() < DEPTH);
    exp_say  = sfire;
    exp_rdy0 = sfire && !win;
    exp_rdy1 = sfire && win;
    if (sfire) begin
      t.who  = win;
      t.meth = win ? req1_meth : req0_meth;
      t.v    = win ? req1_v : req0_v;
      say_q.push_back(t);
    end
    head      = (tagq.size() > 0) ? tagq[0] : -1;
    exp_hrdy  = rn && (head >= 0) && ((head == 1) ? p1 : p0);
    hfire     = exp_hrdy && hena;
    exp_resp0 = hfire && (head == 0);
    exp_resp1 = hfire && (head == 1);
    if (hfire) begin
      t.who  = (head == 1);
      t.meth = hpay;
      t.v    = ~hpay;
      resp_q.push_back(t);
    end
    exp_out  = tagq.size();
    exp_iss0 = iss0;
    exp_iss1 = iss1;

    @(posedge CLK);
    if (!rn) begin
      tagq.delete();
      prio_m = 1'b0;
      iss0 = 0;
      iss1 = 0;
    end else begin
      if (hfire) void'(tagq.pop_front());
      if (sfire) begin
        tagq.push_back(int'(win));
        prio_m = !win;
        if (win) iss1 = (iss1 + 1) % 65536;
        else     iss0 = (iss0 + 1) % 65536;
      end
    end
    #1;
  endtask

  txn_t mt;
  always @(negedge CLK) begin
    if (started) begin
      chk("outstanding", outstanding, exp_out);
      chk("req0_rdy", req0__RDY, exp_rdy0);
      chk("req1_rdy", req1__RDY, exp_rdy1);
      chk("heard_rdy", heard__RDY, exp_hrdy);
      chk("say_ena", say__ENA, exp_say);
      chk("resp0_ena", resp0__ENA, exp_resp0);
      chk("resp1_ena", resp1__ENA, exp_resp1);
`ifdef IVECTOR_SAY_ARBITER_STATS_EN
      chk("issued0", issued0, exp_iss0);
      chk("issued1", issued1, exp_iss1);
`endif
      if (say__ENA === 1'b1) begin
        if (say_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL say_unexpected actual=1 required=0");
        end else begin
          mt = say_q.pop_front();
          chk("say_who", req1__RDY, mt.who);
          chk("say_meth", say_meth, mt.meth);
          chk("say_v", say_v, mt.v);
        end
      end
      if (resp0__ENA === 1'b1 || resp1__ENA === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=1 required=0");
        end else begin
          mt = resp_q.pop_front();
          chk("resp_who", resp1__ENA, mt.who);
          chk("resp_meth", mt.who ? resp1_meth : resp0_meth, mt.meth);
          chk("resp_v", mt.who ? resp1_v : resp0_v, mt.v);
        end
      end
    end
  end

  initial begin
    nRST = 0; req0__ENA = 0; req1__ENA = 0; say__RDY = 0; heard__ENA = 0;
    resp0__RDY = 0; resp1__RDY = 0;
    req0_meth = '0; req0_v = '0; req1_meth = '0; req1_v = '0;
    heard_meth = '0; heard_v = '0;

    cyc(0, 1, 1, 1, 1, 1, 1, rnd192());
    started = 1;
    cyc(0, 1, 1, 1, 1, 1, 1, rnd192());

    // Lone requester 0 issues three calls back to back.
    repeat (3) cyc(1, 1, 0, 1, 0, 1, 1, rnd192());
    chk("three_issued_out", outstanding, 3);
    repeat (4) cyc(1, 0, 0, 1, 1, 1, 1, rnd192());
    chk("drained_out", outstanding, 0);

    // Both requesters contend after reset: alternate 0,1,0,1 and fill the FIFO.
    cyc(0, 0, 0, 0, 0, 0, 0, rnd192());
    repeat (4) cyc(1, 1, 1, 1, 0, 1, 1, rnd192());
    chk("full_out", outstanding, DEPTH);
    cyc(1, 1, 1, 1, 0, 1, 1, rnd192());
    cyc(1, 1, 1, 1, 1, 1, 1, rnd192());
    chk("full_pop_only_out", outstanding, DEPTH - 1);

    // Issue order 1 then 0; indications A then B must follow that order.
    cyc(0, 0, 0, 0, 0, 0, 0, rnd192());
    cyc(1, 0, 1, 1, 0, 1, 1, rnd192());
    cyc(1, 1, 0, 1, 0, 1, 1, rnd192());
    cyc(1, 0, 0, 0, 1, 1, 1, 192'hA);
    cyc(1, 0, 0, 0, 1, 1, 1, 192'hB);

    // Head owed to requester 1 while it is not ready.
    cyc(1, 0, 1, 1, 0, 1, 1, rnd192());
    repeat (2) cyc(1, 0, 0, 0, 1, 1, 0, rnd192());
    chk("blocked_out", outstanding, 1);
    cyc(1, 0, 0, 0, 1, 1, 1, rnd192());

    // Reset with two calls in flight discards them.
    repeat (2) cyc(1, 1, 1, 1, 0, 1, 1, rnd192());
    cyc(0, 0, 0, 0, 1, 1, 1, rnd192());
    chk("reset_out", outstanding, 0);
    repeat (2) cyc(1, 0, 0, 0, 1, 1, 1, rnd192());

    repeat (3000) begin
      cyc(($urandom_range(0, 199) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rnd192());
    end
    cyc(1, 0, 0, 0, 0, 0, 0, rnd192());

    chk("say_q_drained", say_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ivector_say_arbiter.md
IVECTOR_SAY_ARBITER -- requirements
Module: ivector_say_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, 4, depth of the in-order requester-tag FIFO; power of two, 2 to 16.
REQ-002 CLK  input  1  clock; all state updates on posedge CLK.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 reqN__ENA  input  1  requester N (N=0,1) asks to issue a say call; may be held while RDY is low.
REQ-005 reqN_meth, reqN_v  input  192 each  requester N say arguments.
REQ-006 reqN__RDY  output  1  requester N is granted this cycle.
REQ-007 say__ENA  output  1  issues a call to the shared IVector say port.
REQ-008 say_meth, say_v  output  192 each  arguments of the granted requester.
REQ-009 say__RDY  input  1  IVector can accept say.
REQ-010 heard__ENA  input  1  IVector indication, fires only when heard__RDY=1.
REQ-011 heard_meth, heard_v  input  192 each  indication payload.
REQ-012 heard__RDY  output  1  arbiter can accept an indication.
REQ-013 respN__ENA  output  1  forwards the indication to requester N.
REQ-014 respN_meth, respN_v  output  192 each  forwarded payload, copied from heard_meth and heard_v.
REQ-015 respN__RDY  input  1  requester N can accept an indication.
REQ-016 outstanding  output  log2(TAG_DEPTH)+1  number of issued calls still awaiting heard.

Function
REQ-017 Requester N fires when reqN__ENA and reqN__RDY are both high in the same cycle; the same rule applies to heard and respN.
REQ-018 At most one requester is granted per cycle, selected combinationally from reqN__ENA and the priority register prio.
- Both requesters requesting: requester prio wins.
- One requester requesting: that requester wins.
REQ-019 reqN__RDY = say__RDY AND NOT tag_full AND (N is the selected winner).
REQ-020 say__ENA equals the OR of the two reqN fires; say_meth and say_v mux from the winner; the mux is zero-latency and unregistered.
REQ-021 On every say fire, the winner index is pushed into the tag FIFO, and prio is set to NOT winner on the next edge (round-robin).
REQ-022 With no fire, prio holds its value.
REQ-023 tag_full means outstanding == TAG_DEPTH; a push is refused while full, even if a pop occurs in the same cycle.
REQ-024 heard__RDY = tag FIFO non-empty AND respH__RDY, where H is the tag at the FIFO head.
REQ-025 On a heard fire:
- respH__ENA is asserted in the same cycle with the payload passed through.
- The head tag is popped.
- The other respN__ENA stays low.
REQ-026 A simultaneous push and pop leaves outstanding unchanged; the head and tail pointers each wrap modulo TAG_DEPTH.
REQ-027 Responses return to requesters strictly in issue order; the IVector is relied on to answer in order.
REQ-028 When the FIFO is empty, heard__RDY=0 and both respN__ENA=0.

Reset
REQ-029 While nRST=0 at posedge CLK, the following are cleared: tag FIFO empty (pointers 0), outstanding=0, prio=0, and statistics counters 0.
REQ-030 During and after reset, all __ENA outputs are 0 until a new fire occurs.
REQ-031 Tags in flight at reset are discarded; any heard arriving afterwards is blocked (heard__RDY=0).

Configuration
REQ-032 Macro IVECTOR_SAY_ARBITER_STATS_EN adds output issued0 and output issued1 (16 bits each).
- issuedN increments on each reqN fire and wraps from 0xFFFF to 0.
- When the macro is undefined, these ports and counters are absent and the remaining behaviour is identical.

Verification
REQ-033 Only req0__ENA=1 with say__RDY=1 for 3 cycles -> say__ENA high for 3 cycles with req0 data; outstanding reaches 3.
REQ-034 Both ENAs held high for 4 cycles after reset -> grant order 0,1,0,1; prio ends at 0.
REQ-035 TAG_DEPTH=4 with 4 calls issued and no heard -> req0__RDY=req1__RDY=0; heard fire plus req in the same cycle -> pop only, outstanding=3.
REQ-036 Issue order 1,0 followed by two heard with payload 0xA then 0xB -> resp1 receives 0xA, then resp0 receives 0xB.
REQ-037 Head tag=1 with resp1__RDY=0 -> heard__RDY=0 until resp1__RDY=1.
REQ-038 nRST=0 pulse with outstanding=2 -> outstanding=0 and heard__RDY=0 next cycle; with STATS_EN, issued0=issued1=0.
